metaball_animator: RTL



---
 rtl/metaball_animator.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/metaball_animator.sv
// Per-frame ball motion controller: steps each ball one axis per cycle with
// margin bounce, then publishes all positions to the read bank in one edge.

module metaball_axis #(
  parameter int PMIN = 32,
  parameter int PMAX = 607
) (
  input  logic [9:0] p_i,
  input  logic [3:0] v_i,
  output logic [9:0] p_o,
  output logic [3:0] v_o
);
  localparam logic signed [11:0] LO = 12'(PMIN);
  localparam logic signed [11:0] HI = 12'(PMAX);

  logic signed [11:0] n;
  assign n = $signed({2'b00, p_i}) + $signed({{8{v_i[3]}}, v_i});

  // Clamp to the limit and reflect velocity; position never wraps.
  always_comb begin
    p_o = n[9:0];
    v_o = v_i;
    if (n < LO) begin
      p_o = LO[9:0];
      v_o = -v_i;
    end else if (n > HI) begin
      p_o = HI[9:0];
      v_o = -v_i;
    end
  end
endmodule

module metaball_animator #(
  parameter int NUM_BALLS = 3,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int MARGIN    = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       pause,
  input  logic [1:0] rd_idx,
  output logic [9:0] rd_x,
  output logic [9:0] rd_y,
  output logic       busy,
  output logic       update_done
);
  localparam int XMIN = MARGIN;
  localparam int XMAX = H_ACTIVE - 1 - MARGIN;
  localparam int YMIN = MARGIN;
  localparam int YMAX = V_ACTIVE - 1 - MARGIN;
  localparam logic [1:0] LAST = 2'(NUM_BALLS - 1);
  localparam logic [2:0] NB   = 3'(NUM_BALLS);

  localparam logic [3:0][9:0] RST_X  = {10'd240, 10'd480, 10'd320, 10'd160};
  localparam logic [3:0][9:0] RST_Y  = {10'd300, 10'd360, 10'd240, 10'd120};
  localparam logic [3:0][3:0] RST_VX = {4'hE, 4'h1, 4'hD, 4'h2};
  localparam logic [3:0][3:0] RST_VY = {4'hF, 4'hE, 4'h2, 4'h1};

  typedef enum logic [1:0] {IDLE, UPD_X, UPD_Y, PUBLISH} state_t;

  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0][9:0] x_q, x_d, y_q, y_d, px_q, px_d, py_q, py_d;
  logic [3:0][3:0] vx_q, vx_d, vy_q, vy_d;

  logic [9:0] nx, ny;
  logic [3:0] nvx, nvy;

  // One axis step unit per dimension, shared across balls via idx_q.
  metaball_axis #(.PMIN(XMIN), .PMAX(XMAX)) u_ax (
    .p_i(x_q[idx_q]), .v_i(vx_q[idx_q]), .p_o(nx), .v_o(nvx)
  );
  metaball_axis #(.PMIN(YMIN), .PMAX(YMAX)) u_ay (
    .p_i(y_q[idx_q]), .v_i(vy_q[idx_q]), .p_o(ny), .v_o(nvy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      x_q     <= RST_X;
      y_q     <= RST_Y;
      vx_q    <= RST_VX;
      vy_q    <= RST_VY;
      px_q    <= RST_X;
      py_q    <= RST_Y;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      px_q    <= px_d;
      py_q    <= py_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    px_d    = px_q;
    py_d    = py_q;
    case (state_q)
      IDLE: begin
        if (frame_start && !pause) begin
          state_d = UPD_X;
          idx_d   = '0;
        end
      end
      UPD_X: begin
        x_d[idx_q]  = nx;
        vx_d[idx_q] = nvx;
        state_d     = UPD_Y;
      end
      UPD_Y: begin
        y_d[idx_q]  = ny;
        vy_d[idx_q] = nvy;
        if (idx_q < LAST) begin
          idx_d   = idx_q + 2'd1;
          state_d = UPD_X;
        end else begin
          state_d = PUBLISH;
        end
      end
      PUBLISH: begin
        px_d    = x_q;
        py_d    = y_q;
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign update_done = (state_q == PUBLISH);

  always_comb begin
    rd_x = '0;
    rd_y = '0;
    if ({1'b0, rd_idx} < NB) begin
      rd_x = px_q[rd_idx];
      rd_y = py_q[rd_idx];
    end
  end
endmodule
